// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: manual hold/shift/rotate/load/clear modes
// plus an autonomous load-then-shift burst engine with busy/done status.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_par,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ASR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_LOAD = 3'd6,
    M_CLR  = 3'd7
  } mode_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CW-1:0]    w_len_clamped;
  logic             r_dir, w_dir_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir;
    w_done_nxt    = 1'b0;
    w_len_clamped = (burst_len > CW'(WIDTH)) ? CW'(WIDTH) : burst_len;

    unique case (r_state)
      S_IDLE: begin
        // start outranks the manual modes; a zero-length burst only loads and flags done
        if (start) begin
          w_q_nxt   = d_par;
          w_cnt_nxt = w_len_clamped;
          w_dir_nxt = dir;
          if (w_len_clamped == '0) w_done_nxt  = 1'b1;
          else                     w_state_nxt = S_SHIFT;
        end else if (en) begin
          case (mode)
            M_HOLD: w_q_nxt = r_q;
            M_SHL:  w_q_nxt = {r_q[WIDTH-2:0], sin_l};
            M_SHR:  w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
            M_ASR:  w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            M_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            M_LOAD: w_q_nxt = d_par;
            M_CLR:  w_q_nxt = '0;
          endcase
        end
      end
      S_SHIFT: begin
        w_q_nxt   = r_dir ? {sin_r, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], sin_l};
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = (r_state == S_SHIFT);
  assign done   = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: vector table, directed burst/reset sequences and
// random stimulus compared every cycle against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W    = 8;
  localparam int CWB  = $clog2(W + 1);
  localparam int FULL = 256;
  localparam int HALF = 128;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           en;
  logic [2:0]     mode;
  logic [W-1:0]   d_par;
  logic           sin_l;
  logic           sin_r;
  logic           start;
  logic           dir;
  logic [CWB-1:0] burst_len;
  logic [W-1:0]   q;
  logic           sout_l, sout_r, busy, done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d_par(d_par),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .dir(dir), .burst_len(burst_len),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register value as an integer, remaining burst shifts as a count
  int unsigned m_q;
  int          m_rem;
  bit          m_right;
  bit          m_done;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q = 0; m_rem = 0; m_right = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit nd;
    int n;
    nd = 0;
    if (m_rem > 0) begin
      if (m_right) m_q = m_q / 2 + (sin_r ? HALF : 0);
      else         m_q = (m_q * 2) % FULL + (sin_l ? 1 : 0);
      m_rem--;
      if (m_rem == 0) nd = 1;
    end else if (start) begin
      m_q = d_par;
      n = int'(burst_len);
      m_rem = (n > W) ? W : n;
      m_right = dir;
      if (m_rem == 0) nd = 1;
    end else if (en) begin
      case (mode)
        3'd1: m_q = (m_q * 2) % FULL + (sin_l ? 1 : 0);
        3'd2: m_q = m_q / 2 + (sin_r ? HALF : 0);
        3'd3: m_q = m_q / 2 + ((m_q >= HALF) ? HALF : 0);
        3'd4: m_q = (m_q * 2) % FULL + m_q / HALF;
        3'd5: m_q = m_q / 2 + (m_q % 2) * HALF;
        3'd6: m_q = d_par;
        3'd7: m_q = 0;
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  task automatic cmp_model();
    chk("m_q", q, m_q);
    chk("m_busy", busy, (m_rem > 0) ? 1 : 0);
    chk("m_done", done, m_done);
    chk("m_sout_l", sout_l, m_q / HALF);
    chk("m_sout_r", sout_r, m_q % 2);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    cmp_model();
  endtask

  task automatic idle_inputs();
    en = 0; mode = 0; d_par = 0; sin_l = 0; sin_r = 0;
    start = 0; dir = 0; burst_len = 0;
  endtask

  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  logic [7:0] exp_l[8];
  logic [7:0] exp_r[8];
  logic [7:0] pat;

  initial begin
    tbl[0] = '{1'b1, 3'd6, 8'hA6, 1'b0, 1'b0, 8'hA6};
    tbl[1] = '{1'b1, 3'd1, 8'h00, 1'b1, 1'b0, 8'h4D};
    tbl[2] = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hA6};
    tbl[3] = '{1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 8'hD3};
    tbl[4] = '{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'hA7};
    tbl[5] = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 8'h53};
    tbl[6] = '{1'b0, 3'd6, 8'hFF, 1'b1, 1'b1, 8'h53};
    tbl[7] = '{1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h53};
    tbl[8] = '{1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 8'h00};
    tbl[9] = '{1'b0, 3'd1, 8'h00, 1'b1, 1'b1, 8'h00};
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) exp_l[i] = {7'd0, pat[7-i]};
    exp_r[0] = 8'd1;
    for (int i = 1; i < 7; i++) exp_r[i] = 8'd0;
    exp_r[7] = 8'd1;

    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    #12 reset_n = 1'b1;
    chk("init_q", q, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);

    // Manual mode vector table
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; d_par = tbl[i].d;
      sin_l = tbl[i].sl; sin_r = tbl[i].sr;
      step();
      chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
    end

    // Asynchronous reset mid-cycle with q = A5
    en = 1; mode = 3'd6; d_par = 8'hA5;
    step();
    chk("pre_rst_q", q, 8'hA5);
    mid_reset();
    reset_n = 1'b1;
    idle_inputs();

    // Left burst, MSB first on sout_l
    d_par = 8'hA5; burst_len = 4'd8; dir = 0; sin_l = 0; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lb_sout_l%0d", i), sout_l, exp_l[i]);
      chk($sformatf("lb_busy%0d", i), busy, 1);
      chk($sformatf("lb_done%0d", i), done, 0);
      step();
    end
    chk("lb_end_busy", busy, 0);
    chk("lb_end_done", done, 1);
    chk("lb_end_q", q, 8'h00);
    step();
    chk("lb_done_pulse", done, 0);

    // Right burst with length clamped to WIDTH
    d_par = 8'h81; burst_len = 4'd15; dir = 1; sin_r = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb_sout_r%0d", i), sout_r, exp_r[i]);
      chk($sformatf("rb_busy%0d", i), busy, 1);
      step();
    end
    chk("rb_end_busy", busy, 0);
    chk("rb_end_done", done, 1);
    chk("rb_end_q", q, 8'hFF);

    // Zero-length burst
    idle_inputs();
    d_par = 8'h5A; start = 1;
    step();
    start = 0;
    chk("z_q", q, 8'h5A);
    chk("z_busy", busy, 0);
    chk("z_done", done, 1);
    step();
    chk("z_done_off", done, 0);

    // Inputs ignored while busy
    d_par = 8'hF0; burst_len = 4'd4; dir = 0; sin_l = 0; start = 1;
    step();
    start = 0; en = 1; mode = 3'd6; d_par = 8'hFF; dir = 1; burst_len = 0;
    step();
    chk("ign_q1", q, 8'hE0);
    start = 1;
    step();
    start = 0;
    step();
    step();
    chk("ign_end_q", q, 8'h00);
    chk("ign_end_done", done, 1);
    idle_inputs();
    step();

    // Start held high: back-to-back burst begins on the done cycle
    d_par = 8'hC3; burst_len = 4'd2; dir = 0; sin_l = 1; start = 1;
    step();
    step();
    chk("bb_q1", q, 8'h87);
    step();
    chk("bb_done", done, 1);
    chk("bb_q2", q, 8'h0F);
    step();
    chk("bb_restart_busy", busy, 1);
    chk("bb_restart_q", q, 8'hC3);
    chk("bb_restart_done", done, 0);
    start = 0;
    step();
    step();

    // Reset at shift 3 of 8
    d_par = 8'h3C; burst_len = 4'd8; dir = 0; sin_l = 1; start = 1;
    step();
    start = 0;
    step(); step(); step();
    mid_reset();
    step(); step();
    chk("rb_hold_q", q, 0);
    chk("rb_hold_done", done, 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    d_par = 8'h96; burst_len = 4'd1; dir = 1; sin_r = 0; start = 1;
    step();
    start = 0;
    chk("post_rst_busy", busy, 1);
    step();
    chk("post_rst_q", q, 8'h4B);
    chk("post_rst_fin", done, 1);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      en = 1'($urandom); mode = 3'($urandom); d_par = 8'($urandom);
      sin_l = 1'($urandom); sin_r = 1'($urandom); dir = 1'($urandom);
      burst_len = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the team's single-bit resettable left shift register.
- Provides a WIDTH-bit register with a per-cycle mode select: hold, logical shifts, arithmetic shift, rotates, parallel load and clear.
- Adds an autonomous burst engine: loads a word, then shifts it out serially for a programmed number of cycles, with busy/done status.
- Used as a parallel-to-serial / serial-to-parallel converter and as a general datapath shifter.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CW, $clog2(WIDTH+1), width of burst_len (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  enables manual mode operation; ignored while busy.
- mode  input  3  manual operation select (see Behaviour).
- d_par  input  WIDTH  parallel load data.
- sin_l  input  1  serial bit entering q[0] on left shifts.
- sin_r  input  1  serial bit entering q[WIDTH-1] on logical right shifts.
- start  input  1  begins a burst; sampled only when idle.
- dir  input  1  burst direction, sampled with start: 0 = left, 1 = right (logical).
- burst_len  input  CW  number of shifts after the load (clamped to WIDTH).
- q  output  WIDTH  register contents.
- sout_l  output  1  combinational copy of q[WIDTH-1] (left-shift serial out).
- sout_r  output  1  combinational copy of q[0] (right-shift serial out).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (reset_n low, asynchronous): q=0, busy=0, done=0, FSM=IDLE, shift counter=0. These values hold while reset_n is low.
- Reset mid-burst aborts the burst immediately and produces no done pulse.
- All state and outputs except sout_l/sout_r are registered on the rising edge of clk.

Manual modes (IDLE, en=1, start=0):
- 0 hold.
- 1 SHL: q <= {q[W-2:0], sin_l}.
- 2 SHR: q <= {sin_r, q[W-1:1]}.
- 3 ASR: q <= {q[W-1], q[W-1:1]}.
- 4 ROL: q <= {q[W-2:0], q[W-1]}.
- 5 ROR: q <= {q[0], q[W-1:1]}.
- 6 LOAD: q <= d_par.
- 7 CLR: q <= 0.
- With en=0, q holds.

FSM with two states, IDLE and SHIFT:
- IDLE, start=1: q <= d_par, cnt <= min(burst_len, WIDTH), and dir is latched. start has priority over en/mode in the same cycle.
  - If the clamped length is 0: stay in IDLE, busy stays 0, done=1 in the next cycle.
  - Otherwise: go to SHIFT, busy=1.
- SHIFT, each edge: shift in the latched direction. Left takes sin_l at bit 0; right takes sin_r at bit MSB. Then cnt decrements.
  - When cnt reaches 0 on this edge: go to IDLE, busy=0, done=1 for exactly one cycle.
- Timing for burst length N>0: busy is high for N cycles starting the cycle after the start edge. q shows the loaded word for one cycle, then N shifted values. done goes high in the same cycle busy falls.
- Serial output ordering: sout_l presents MSB-first on left bursts; sout_r presents LSB-first on right bursts.
- Inputs ignored while busy: start, en, mode, d_par, burst_len and dir. A start held high through completion triggers a new burst on the first IDLE edge, i.e. the cycle done is high.
- burst_len > WIDTH is clamped to WIDTH. Shifting WIDTH times fully replaces q with serial-in bits.

Test Plan:
- Reset: drive reset_n low asynchronously mid-cycle with q=8'hA5 -> q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Manual modes, WIDTH=8: LOAD 8'b1010_0110, then SHL with sin_l=1 -> 8'h4D. ROR -> 8'hA6. ASR -> 8'hD3. ROL -> 8'hA7. SHR with sin_r=0 -> 8'h53. CLR -> 8'h00. en=0 with any mode -> q unchanged.
- Left burst: d_par=8'hA5, burst_len=8, sin_l=0, start for 1 cycle -> sout_l sequence 1,0,1,0,0,1,0,1. busy high for 8 cycles, done single pulse with busy's fall, final q=8'h00.
- Right burst with clamp: d_par=8'h81, dir=1, burst_len=15, sin_r=1 -> 8 shifts only. sout_r sequence 1,0,0,0,0,0,0,1. Final q=8'hFF, done after exactly 8 busy cycles.
- Zero length and overlap: burst_len=0 -> q=d_par, busy never set, done pulses next cycle. Start and mode changes during busy are ignored. Start held high through completion -> back-to-back burst begins on the done cycle.
- Reset mid-burst: assert reset_n low at shift 3 of 8 -> q=0, busy=0, no done pulse. After release, a new start works normally.
